// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and parameter limits for the debounce filter
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    function automatic logic is_wait(input state_t s);
        return (s == WAIT_HIGH) || (s == WAIT_LOW);
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// rtl/sync_ff_chain.sv - plain async active-low reset flop chain used as the input synchroniser
module sync_ff_chain
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_stage_chk
        $error("sync_ff_chain: SYNC_STAGES out of range");
    end

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronise and debounce a raw level into a clean registered q
// Optional rise/fall pulse registers are built only when DEBOUNCE_PULSE_OUT_EN is defined.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic data_in,
    input  logic enable,
    output logic q,
    output logic busy,
    output logic rise,
    output logic fall
);

    if ((2 ** CNT_W) < STABLE_CNT) begin : g_cnt_w_chk
        $error("debounce_sync: CNT_W too narrow for STABLE_CNT");
    end
    if (STABLE_CNT < 2) begin : g_stable_chk
        $error("debounce_sync: STABLE_CNT must be at least 2");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             q_nxt;

    sync_ff_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (data_in),
        .q    (s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            q     <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            q     <= q_nxt;
            busy  <= is_wait(state_nxt);
        end
    end

    // Everything holds while enable is low; the synchroniser keeps sampling regardless.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = q;
        if (enable) begin
            case (state)
                STABLE_LOW: begin
                    if (s) begin
                        state_nxt = WAIT_HIGH;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state_nxt = STABLE_LOW;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_HIGH;
                        q_nxt     = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state_nxt = WAIT_LOW;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state_nxt = STABLE_HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_LOW;
                        q_nxt     = 1'b0;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = STABLE_LOW;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_PULSE_OUT_EN
    // q only moves on acceptance, so its edge is exactly the rise/fall event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= q_nxt & ~q;
            fall <= ~q_nxt & q;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - directed table-driven bench for debounce_sync
module tb_debounce_sync;

`ifdef DEBOUNCE_PULSE_OUT_EN
    localparam logic P = 1'b1;
`else
    localparam logic P = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic data_in = 1'b1;
    logic enable = 1'b1;
    logic q, busy, rise, fall;

    debounce_sync dut (
        .clk    (clk),
        .reset  (reset),
        .data_in(data_in),
        .enable (enable),
        .q      (q),
        .busy   (busy),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic din;
        logic en;
        int   edges;
        logic eq;
        logic ebusy;
        logic erise;
        logic efall;
    } vec_t;

    vec_t vecs[$];
    int   phase_a_len;
    int   compared = 0;
    int   mismatched = 0;
    int   rise_cnt = 0;
    int   fall_cnt = 0;
    int   both_cnt = 0;

    always @(negedge clk) begin
        if (rise === 1'b1) rise_cnt++;
        if (fall === 1'b1) fall_cnt++;
        if (rise === 1'b1 && fall === 1'b1) both_cnt++;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic din, input logic en, input int edges,
                                input logic eq, input logic eb, input logic er, input logic ef);
        vec_t v;
        v.din = din; v.en = en; v.edges = edges;
        v.eq = eq; v.ebusy = eb; v.erise = er; v.efall = ef;
        return v;
    endfunction

    task automatic add_fall();
        vecs.push_back(mk(0, 1, 11, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1,  0, 0, 0, P));
        vecs.push_back(mk(0, 1, 1,  0, 0, 0, 0));
    endtask

    task automatic add_rise();
        vecs.push_back(mk(1, 1, 11, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1,  1, 0, P, 0));
        vecs.push_back(mk(1, 1, 1,  1, 0, 0, 0));
    endtask

    task automatic run_vec(input int idx);
        data_in = vecs[idx].din;
        enable  = vecs[idx].en;
        repeat (vecs[idx].edges) @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_q", idx),    q,    vecs[idx].eq);
        chk($sformatf("v%0d_busy", idx), busy, vecs[idx].ebusy);
        chk($sformatf("v%0d_rise", idx), rise, vecs[idx].erise);
        chk($sformatf("v%0d_fall", idx), fall, vecs[idx].efall);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_q"},    q,    1'b0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_rise"}, rise, 1'b0);
        chk({name, "_fall"}, fall, 1'b0);
    endtask

    initial begin
        // power-up qualification with data_in held high through reset
        vecs.push_back(mk(1, 1, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 8, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, P, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0));
        // 50 ns low glitch
        vecs.push_back(mk(0, 1, 3, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 2, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 15, 1, 0, 0, 0));
        // full fall, rise, fall
        add_fall();
        add_rise();
        add_fall();
        // enable pause at cnt=5 adds exactly four edges
        vecs.push_back(mk(1, 1, 7, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 4, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 4, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, P, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0));
        // back to low, then park in WAIT_HIGH at cnt=7
        add_fall();
        vecs.push_back(mk(1, 1, 9, 0, 1, 0, 0));
        phase_a_len = vecs.size();
        add_rise();

        #3;
        chk_all_zero("rst_t3");
        @(negedge clk);
        chk_all_zero("rst_t10");
        @(negedge clk);
        chk_all_zero("rst_t20");
        reset = 1'b1;

        for (int i = 0; i < phase_a_len; i++) run_vec(i);

        // asynchronous reset in the middle of a clock period
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        chk_all_zero("async_rst_held");
        reset = 1'b1;

        for (int i = phase_a_len; i < vecs.size(); i++) run_vec(i);

        chk_int("rise_pulses", rise_cnt, P ? 4 : 0);
        chk_int("fall_pulses", fall_cnt, P ? 3 : 0);
        chk_int("pulse_overlap", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
